// File: rtl/ex_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_issue_stage_pkg
//  Description : Shared ALU opcode enum, issue-stage widths, the buffered
//                entry type and the forwarding match helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_issue_stage_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // Operation codes understood by the execute-stage ALU.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSY = 4'd10
  } AluOp;

  // One buffered issue entry (main or skid slot).
  typedef struct packed {
    logic            valid;
    AluOp            op;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic [REGW-1:0] rd;
    logic            wen;
  } ex_entry_t;

  // A bypass port matches an operand only when the operand really reads a
  // register other than x0 and the producer is writing that register.
  function automatic logic fwd_match(input logic            wen,
                                     input logic [REGW-1:0] rd,
                                     input logic            use_rs,
                                     input logic [REGW-1:0] rs);
    return use_rs && (rs != '0) && wen && (rd == rs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_issue_stage_if
//  Description : Decode-side valid/ready entry bus plus the ALU / EX-MEM side
//                outputs of the issue stage. The master modport is the
//                environment (decode + downstream), slave is the issue stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_issue_stage_if;
  import ex_issue_stage_pkg::*;

  logic            in_valid;
  logic            in_ready;
  AluOp            in_op;
  logic [XLEN-1:0] in_x;
  logic [XLEN-1:0] in_y;
  logic [REGW-1:0] in_rs1;
  logic [REGW-1:0] in_rs2;
  logic            in_use_rs1;
  logic            in_use_rs2;
  logic [REGW-1:0] in_rd;
  logic            in_wen;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_x;
  logic [XLEN-1:0] alu_y;
  AluOp            alu_s;
  logic [REGW-1:0] out_rd;
  logic            out_wen;

  modport master (
    output in_valid, in_op, in_x, in_y, in_rs1, in_rs2,
           in_use_rs1, in_use_rs2, in_rd, in_wen, out_ready,
    input  in_ready, out_valid, alu_x, alu_y, alu_s, out_rd, out_wen
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, in_rs1, in_rs2,
           in_use_rs1, in_use_rs2, in_rd, in_wen, out_ready,
    output in_ready, out_valid, alu_x, alu_y, alu_s, out_rd, out_wen
  );

endinterface
`default_nettype wire

// File: rtl/ex_issue_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ex_fwd_mux
//  Description : Resolves one stored operand against the MEM and WB bypass
//                ports (MEM has priority). The hit flag tells the owner to
//                write the resolved value back into its stored operand.
//                Build macro: EX_FWD_EN (undefined = pass stored value, no hit).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_fwd_mux
  import ex_issue_stage_pkg::*;
(
  input  wire logic [XLEN-1:0] i_val,
  input  wire logic [REGW-1:0] i_rs,
  input  wire logic            i_use,
  input  wire logic            i_mem_wen,
  input  wire logic [REGW-1:0] i_mem_rd,
  input  wire logic [XLEN-1:0] i_mem_data,
  input  wire logic            i_wb_wen,
  input  wire logic [REGW-1:0] i_wb_rd,
  input  wire logic [XLEN-1:0] i_wb_data,
  output logic      [XLEN-1:0] o_val,
  output logic                 o_hit
);

`ifdef EX_FWD_EN
  // Priority select: MEM is the younger producer, so it wins over WB.
  always_comb begin
    o_val = i_val;
    o_hit = 1'b0;
    if (fwd_match(i_mem_wen, i_mem_rd, i_use, i_rs)) begin
      o_val = i_mem_data;
      o_hit = 1'b1;
    end else if (fwd_match(i_wb_wen, i_wb_rd, i_use, i_rs)) begin
      o_val = i_wb_data;
      o_hit = 1'b1;
    end
  end
`else
  // Hazards are interlocked in decode; bypass inputs are deliberately unused.
  wire logic w_unused_fwd = ^{i_rs, i_use, i_mem_wen, i_mem_rd, i_mem_data,
                              i_wb_wen, i_wb_rd, i_wb_data};

  assign o_val = i_val;
  assign o_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/ex_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_issue_stage
//  Description : ID/EX issue stage. Two-entry (main + skid) buffer behind a
//                valid/ready handshake, MEM/WB operand forwarding with
//                in-place refresh of stalled entries, synchronous flush.
//                Build macro: EX_FWD_EN enables forwarding and refresh.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_issue_stage
  import ex_issue_stage_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            flush,
  input  wire logic            fwd_mem_wen,
  input  wire logic [REGW-1:0] fwd_mem_rd,
  input  wire logic [XLEN-1:0] fwd_mem_data,
  input  wire logic            fwd_wb_wen,
  input  wire logic [REGW-1:0] fwd_wb_rd,
  input  wire logic [XLEN-1:0] fwd_wb_data,
  ex_issue_stage_if.slave      bus
);

  ex_entry_t       r_main;
  ex_entry_t       r_skid;

  ex_entry_t       w_in_entry;
  ex_entry_t       w_main_ref;
  ex_entry_t       w_skid_ref;
  logic            w_accept;
  logic            w_pop;
  logic            w_in_ready;

  logic [XLEN-1:0] w_mx;
  logic [XLEN-1:0] w_my;
  logic [XLEN-1:0] w_sx;
  logic [XLEN-1:0] w_sy;
  logic            w_mx_hit;
  logic            w_my_hit;
  logic            w_sx_hit;
  logic            w_sy_hit;

  // Readiness depends only on stored state, never on out_ready.
  assign w_in_ready = !r_skid.valid && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_pop      = r_main.valid && bus.out_ready;

  // Pack the decode-side fields into an entry.
  always_comb begin
    w_in_entry         = '0;
    w_in_entry.valid   = 1'b1;
    w_in_entry.op      = bus.in_op;
    w_in_entry.x       = bus.in_x;
    w_in_entry.y       = bus.in_y;
    w_in_entry.rs1     = bus.in_rs1;
    w_in_entry.rs2     = bus.in_rs2;
    w_in_entry.use_rs1 = bus.in_use_rs1;
    w_in_entry.use_rs2 = bus.in_use_rs2;
    w_in_entry.rd      = bus.in_rd;
    w_in_entry.wen     = bus.in_wen;
  end

  ex_fwd_mux u_fwd_main_x (
    .i_val(r_main.x), .i_rs(r_main.rs1), .i_use(r_main.use_rs1),
    .i_mem_wen(fwd_mem_wen), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_wen(fwd_wb_wen), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_val(w_mx), .o_hit(w_mx_hit)
  );

  ex_fwd_mux u_fwd_main_y (
    .i_val(r_main.y), .i_rs(r_main.rs2), .i_use(r_main.use_rs2),
    .i_mem_wen(fwd_mem_wen), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_wen(fwd_wb_wen), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_val(w_my), .o_hit(w_my_hit)
  );

  ex_fwd_mux u_fwd_skid_x (
    .i_val(r_skid.x), .i_rs(r_skid.rs1), .i_use(r_skid.use_rs1),
    .i_mem_wen(fwd_mem_wen), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_wen(fwd_wb_wen), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_val(w_sx), .o_hit(w_sx_hit)
  );

  ex_fwd_mux u_fwd_skid_y (
    .i_val(r_skid.y), .i_rs(r_skid.rs2), .i_use(r_skid.use_rs2),
    .i_mem_wen(fwd_mem_wen), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_wen(fwd_wb_wen), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_val(w_sy), .o_hit(w_sy_hit)
  );

  // Refreshed copies: forward-matched operands overwrite the stored ones.
  always_comb begin
    w_main_ref = r_main;
    w_skid_ref = r_skid;
    if (w_mx_hit) w_main_ref.x = w_mx;
    if (w_my_hit) w_main_ref.y = w_my;
    if (w_sx_hit) w_skid_ref.x = w_sx;
    if (w_sy_hit) w_skid_ref.y = w_sy;
  end

  // Buffer update: hold+refresh, skid->main move, or accept into a free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_main.valid <= 1'b0;
      r_skid.valid <= 1'b0;
    end else if (r_main.valid && !w_pop) begin
      // Main is stalled: both slots keep their (refreshed) contents.
      r_main <= w_main_ref;
      if (r_skid.valid) begin
        r_skid <= w_skid_ref;
      end else if (w_accept) begin
        r_skid <= w_in_entry;
      end
    end else if (r_skid.valid) begin
      // Main leaves and skid slides forward with refreshed operands.
      r_main <= w_skid_ref;
      if (w_accept) begin
        r_skid <= w_in_entry;
      end else begin
        r_skid.valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_main <= w_in_entry;
    end else begin
      r_main.valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_main.valid;
  assign bus.alu_x     = r_main.valid ? w_mx      : '0;
  assign bus.alu_y     = r_main.valid ? w_my      : '0;
  assign bus.alu_s     = r_main.valid ? r_main.op : ALU_ADD;
  assign bus.out_rd    = r_main.valid ? r_main.rd : '0;
  assign bus.out_wen   = r_main.valid && r_main.wen;

endmodule
`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_issue_stage
//  Description : Directed self-checking bench for ex_issue_stage. Expected
//                forwarding results follow the EX_FWD_EN build macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_issue_stage;
  import ex_issue_stage_pkg::*;

`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            flush;
  logic            fwd_mem_wen;
  logic [REGW-1:0] fwd_mem_rd;
  logic [XLEN-1:0] fwd_mem_data;
  logic            fwd_wb_wen;
  logic [REGW-1:0] fwd_wb_rd;
  logic [XLEN-1:0] fwd_wb_data;

  int checks = 0;
  int errors = 0;

  ex_issue_stage_if bus ();

  ex_issue_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fwd_mem_wen  (fwd_mem_wen),
    .fwd_mem_rd   (fwd_mem_rd),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_wen   (fwd_wb_wen),
    .fwd_wb_rd    (fwd_wb_rd),
    .fwd_wb_data  (fwd_wb_data),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic wen);
    bus.in_valid   = 1'b1;
    bus.in_op      = AluOp'(op);
    bus.in_x       = x;
    bus.in_y       = y;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_rs1 = u1;
    bus.in_use_rs2 = u2;
    bus.in_rd      = rd;
    bus.in_wen     = wen;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic fwd_clear();
    fwd_mem_wen  = 1'b0;
    fwd_mem_rd   = '0;
    fwd_mem_data = '0;
    fwd_wb_wen   = 1'b0;
    fwd_wb_rd    = '0;
    fwd_wb_data  = '0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fwd_clear();
    bus.out_ready = 1'b0;
    offer(4'd0, 32'h99, 32'h98, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1);
    step();
    step();

    // Reset state (an offer during reset must be dropped)
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_x",     bus.alu_x,     0);
    chk("rst_alu_y",     bus.alu_y,     0);
    chk("rst_alu_s",     bus.alu_s,     0);
    chk("rst_out_rd",    bus.out_rd,    0);
    chk("rst_out_wen",   bus.out_wen,   0);

    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_in_ready",  bus.in_ready,  1);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // Single accept: ADD 5,7 visible one cycle later
    offer(4'd0, 32'd5, 32'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
    step();
    idle();
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_alu_x",     bus.alu_x,     5);
    chk("t1_alu_y",     bus.alu_y,     7);
    chk("t1_alu_s",     bus.alu_s,     0);
    chk("t1_out_rd",    bus.out_rd,    1);
    chk("t1_out_wen",   bus.out_wen,   1);

    bus.out_ready = 1'b1;
    step();
    chk("t1_pop_valid", bus.out_valid, 0);
    chk("t1_pop_wen",   bus.out_wen,   0);
    chk("t1_pop_alu_x", bus.alu_x,     0);

    // Stall: three offers, only two taken
    bus.out_ready = 1'b0;
    offer(4'd1, 32'h10, 32'h1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
    step();
    offer(4'd2, 32'h20, 32'h2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    chk("stall_ready_one", bus.in_ready, 1);
    step();
    chk("stall_full_ready", bus.in_ready, 0);
    offer(4'd3, 32'h30, 32'h3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    step();
    idle();
    chk("stall_head_x", bus.alu_x,    32'h10);
    chk("stall_head_s", bus.alu_s,    1);
    chk("stall_ready",  bus.in_ready, 0);

    bus.out_ready = 1'b1;
    step();
    chk("drain_second_x",  bus.alu_x,     32'h20);
    chk("drain_second_rd", bus.out_rd,    3);
    chk("drain_ready",     bus.in_ready,  1);
    step();
    chk("drain_empty", bus.out_valid, 0);

    // Back-to-back with out_ready high
    offer(4'd0, 32'h40, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    step();
    chk("b2b_first_x", bus.alu_x, 32'h40);
    offer(4'd0, 32'h50, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1);
    step();
    idle();
    chk("b2b_second_x",     bus.alu_x,     32'h50);
    chk("b2b_second_valid", bus.out_valid, 1);
    step();
    chk("b2b_empty", bus.out_valid, 0);

    // MEM forward on stalled main, then refresh after the pulse
    bus.out_ready = 1'b0;
    offer(4'd0, 32'h1, 32'h2, 5'd3, 5'd3, 1'b1, 1'b0, 5'd2, 1'b1);
    step();
    idle();
    fwd_mem_wen = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;
    #1;
    chk("fwd_mem_x",   bus.alu_x, FWD ? 32'hAA : 32'h1);
    chk("fwd_nouse_y", bus.alu_y, 32'h2);
    step();
    fwd_clear();
    #1;
    chk("refresh_x", bus.alu_x, FWD ? 32'hAA : 32'h1);

    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // MEM over WB priority; rs=0 never forwarded
    offer(4'd0, 32'h6, 32'h5, 5'd0, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1);
    step();
    idle();
    fwd_mem_wen = 1'b1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'h11;
    fwd_wb_wen  = 1'b1; fwd_wb_rd  = 5'd4; fwd_wb_data  = 32'h22;
    #1;
    chk("prio_mem_y", bus.alu_y, FWD ? 32'h11 : 32'h5);
    fwd_mem_rd = 5'd0; fwd_mem_data = 32'h33;
    #1;
    chk("rs0_x",  bus.alu_x, 32'h6);
    chk("wb_y",   bus.alu_y, FWD ? 32'h22 : 32'h5);
    fwd_clear();
    #1;
    chk("no_edge_no_refresh_y", bus.alu_y, 32'h5);

    // Skid entry refreshed while stalled, carried into main
    offer(4'd0, 32'h1, 32'h0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1);
    step();
    idle();
    fwd_mem_wen = 1'b1; fwd_mem_rd = 5'd7; fwd_mem_data = 32'h77;
    step();
    fwd_clear();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("skid_refresh_x", bus.alu_x, FWD ? 32'h77 : 32'h1);

    // Flush with both entries full and an offer present
    offer(4'd2, 32'hC, 32'hD, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    step();
    chk("flush_pre_full", bus.in_ready, 0);
    flush = 1'b1;
    offer(4'd3, 32'hE, 32'hF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1);
    step();
    flush = 1'b0;
    idle();
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready",  bus.in_ready,  1);
    chk("flush_alu_x",     bus.alu_x,     0);
    chk("flush_alu_y",     bus.alu_y,     0);
    chk("flush_alu_s",     bus.alu_s,     0);
    chk("flush_out_rd",    bus.out_rd,    0);
    chk("flush_out_wen",   bus.out_wen,   0);
    step();
    chk("flush_dropped", bus.out_valid, 0);

    // Reset in the middle of a stall
    offer(4'd0, 32'h1, 32'h1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
    step();
    offer(4'd0, 32'h2, 32'h2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
    step();
    rst = 1'b1;
    step();
    chk("midrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    idle();
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready_after", bus.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
